// File: rtl/fetch_decode_reg_pkg.sv
// Shared core package: datapath width, reset/NOP defaults and the
// per-entry payload type, reused by the PC, fetch/decode and decode blocks.
package fetch_decode_reg_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  // Payload held by one pipeline entry (valid bit lives beside it).
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } slot_t;

  // Word alignment check on the low PC bits.
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_decode_reg_slot.sv
// pipe_slot: one pipeline entry (valid + instr + pc + misalign).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ld         load d and set valid (wins over clr)
//   clr        clear valid only; payload is held
//   d          payload to load
//   valid, q   registered entry state
module pipe_slot
  import fetch_decode_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  ld,
  input  logic  clr,
  input  slot_t d,
  output logic  valid,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= RESET_PC;
      q.misalign <= 1'b0;
    end else if (ld) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: valid/ready pipeline register between fetch and decode.
// Build option: define FETCH_DECODE_SKID_EN for a two-entry (main + skid)
// version whose if_ready depends only on registered state; default is a
// single entry with a combinational if_ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_valid/if_instr/if_pc       fetch-side word
//   if_ready                      block accepts a fetch word this cycle
//   flush                         drop all held words and any incoming word
//   id_valid/id_instr/id_pc       decode-side word (NOP_INSTR when invalid)
//   id_misalign                   presented PC not word aligned
//   id_ready                      decode consumes the word this cycle
module fetch_decode_reg
  import fetch_decode_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misalign,
  input  logic            id_ready
);

  slot_t in_word, main_d, main_q;
  logic  main_v, main_ld, main_clr;
  logic  xfer_in, xfer_out;

  // Misalign is captured at acceptance, travelling with the word.
  assign in_word = '{instr: if_instr, pc: if_pc, misalign: is_misaligned(if_pc[1:0])};

  assign xfer_in  = if_valid && if_ready;
  assign xfer_out = main_v && id_ready;

`ifdef FETCH_DECODE_SKID_EN
  slot_t skid_q;
  logic  skid_v, skid_ld, skid_clr;

  // skid_v only sets when main is full, so a full skid always means
  // main is full; if_ready is purely a function of that register.
  assign if_ready = !skid_v;

  // With skid full, the next transfer out promotes skid into main.
  // Otherwise an incoming word goes to main if main is free or leaving,
  // and into skid if main is stalled.
  assign main_d   = skid_v ? skid_q : in_word;
  assign main_ld  = !flush && (skid_v ? xfer_out : (xfer_in && (!main_v || xfer_out)));
  assign main_clr = flush || xfer_out;
  assign skid_ld  = !flush && xfer_in && main_v && !xfer_out;
  assign skid_clr = flush || (skid_v && xfer_out);

  pipe_slot #(.NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)) u_skid (
    .clk(clk), .rst(rst), .ld(skid_ld), .clr(skid_clr),
    .d(in_word), .valid(skid_v), .q(skid_q)
  );
`else
  assign if_ready = !main_v || id_ready;
  assign main_d   = in_word;
  assign main_ld  = xfer_in && !flush;
  assign main_clr = flush || xfer_out;
`endif

  pipe_slot #(.NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .clr(main_clr),
    .d(main_d), .valid(main_v), .q(main_q)
  );

  // Invalid output shows NOP and no misalign; the PC keeps its last value.
  assign id_valid    = main_v;
  assign id_instr    = main_v ? main_q.instr : NOP_INSTR;
  assign id_pc       = main_q.pc;
  assign id_misalign = main_v && main_q.misalign;

endmodule

// File: tb/tb_fetch_decode_reg.sv
module tb_fetch_decode_reg;

`ifdef FETCH_DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, id_valid, id_misalign;
  logic [31:0] id_instr, id_pc;

  fetch_decode_reg dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_misalign(id_misalign), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of accepted words with capacity CAP.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } word_t;
  word_t       q[$];
  logic [31:0] last_pc;
  bit          known = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic mdl_ready(input logic rdy);
    if (CAP == 2) return q.size() < 2;
    return q.size() == 0 || rdy;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic rdy, input logic r);
    logic ev, er;
    word_t w;
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl; id_ready = rdy; rst = r;
    @(negedge clk);
    ev = q.size() > 0;
    er = mdl_ready(rdy);
    if (known) begin
      chk("id_valid", {31'd0, id_valid}, {31'd0, ev});
      chk("id_instr", id_instr, ev ? q[0].instr : NOP);
      chk("id_pc", id_pc, ev ? q[0].pc : last_pc);
      chk("id_misalign", {31'd0, id_misalign}, {31'd0, ev && (q[0].pc % 4 != 0)});
      chk("if_ready", {31'd0, if_ready}, {31'd0, er});
    end
    if (r) begin
      q.delete();
      last_pc = RPC;
      known = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (v && er) begin
        w.instr = ins; w.pc = pc;
        q.push_back(w);
      end
    end
    if (q.size() > 0) last_pc = q[0].pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; id_ready = 0;
    // reset held two cycles
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    // streaming, no bubble
    step(1, 32'h0000_2300, 32'h0, 0, 1, 0);
    step(1, 32'h0000_1514, 32'h4, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // backpressure with a held word, extra words offered
    step(1, 32'h0700_6430, 32'h8, 0, 1, 0);
    step(1, 32'h1111_0001, 32'hC, 0, 0, 0);
    step(1, 32'h2222_0002, 32'h10, 0, 0, 0);
    step(1, 32'h3333_0003, 32'h14, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush with two words held and a word incoming
    step(1, 32'hAAAA_0001, 32'h20, 0, 0, 0);
    step(1, 32'hAAAA_0002, 32'h24, 0, 0, 0);
    step(1, 32'hDEAD_BEEF, 32'h28, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush with id_ready together
    step(1, 32'hBBBB_0001, 32'h30, 0, 1, 0);
    step(1, 32'hBBBB_0002, 32'h34, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // misalign
    step(1, 32'h0000_0013, 32'h6, 0, 1, 0);
    step(1, 32'h0000_0093, 32'h8, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // reset mid-stall with entries full
    step(1, 32'hCCCC_0001, 32'h40, 0, 0, 0);
    step(1, 32'hCCCC_0002, 32'h44, 0, 0, 0);
    step(1, 32'hCCCC_0003, 32'h48, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) rpc[1:0] = 2'($urandom_range(3));
      step(($urandom_range(3) != 0), $urandom, rpc, ($urandom_range(15) == 0),
           ($urandom_range(9) < 6), ($urandom_range(63) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_reg.md
FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word driven on id_instr when id_valid is 0.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the value driven on id_pc after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-006 if_instr  input  32  fetched instruction word (little-endian byte assembly already done upstream).
REQ-007 if_pc  input  32  address the instruction was fetched from.
REQ-008 if_ready  output  1  block accepts a fetch word this cycle.
REQ-009 flush  input  1  discard all held instructions (branch/jump redirect).
REQ-010 id_valid  output  1  decode-side word valid.
REQ-011 id_instr  output  32  instruction to decode.
REQ-012 id_pc  output  32  PC of id_instr.
REQ-013 id_misalign  output  1  id_pc[1:0] != 0 for the presented word.
REQ-014 id_ready  input  1  decode stage consumes the word this cycle.

Function
REQ-015 A transfer in SHALL occur when if_valid && if_ready; a transfer out SHALL occur when id_valid && id_ready.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N appears on id_* after edge N when the block was empty.
REQ-017 id_instr, id_pc and id_misalign SHALL hold stable while id_valid && !id_ready.
REQ-018 When id_valid is 0, id_instr SHALL equal NOP_INSTR and id_misalign SHALL be 0; id_pc SHALL hold its last value.
REQ-019 Words SHALL leave in acceptance order; none duplicated, none dropped except by flush or rst.
REQ-020 id_misalign SHALL be registered together with the word, computed from if_pc[1:0] at acceptance.
REQ-021 On flush, all held valid bits SHALL clear at the next edge; an if_valid word in the same cycle SHALL be dropped (flush wins).
REQ-022 flush and id_ready asserted together: the current word SHALL count as consumed; the block SHALL still empty.
REQ-023 Simultaneous in and out transfers while one word is held SHALL replace the word with no bubble.

Reset
REQ-024 On rst: id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC, id_misalign=0, skid entry invalid.
REQ-025 rst SHALL take priority over flush and any transfer in the same cycle; a word in flight SHALL be lost.
REQ-026 if_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-027 Macro FETCH_DECODE_SKID_EN SHALL select the buffering scheme.
REQ-028 With FETCH_DECODE_SKID_EN: two entries (main + skid); if_ready is registered (= !skid_valid), with no combinational path from id_ready to if_ready; a word arriving while main is stalled goes to skid and is promoted to main on the next transfer out.
REQ-029 Without FETCH_DECODE_SKID_EN: single entry; if_ready = !id_valid || id_ready, combinational.
REQ-030 Ordering, flush and reset behaviour SHALL be identical in both builds.

Structure
REQ-031 XLEN (32), the NOP_INSTR default and the RESET_PC default SHALL live in the shared core package, reused by the PC and decode blocks.
REQ-032 One sub-module, pipe_slot (valid + instr + pc + misalign register with load/clear), SHALL be instantiated once per entry.

Verification
REQ-033 Reset: hold rst 2 cycles -> id_valid=0, id_instr=32'h0, id_pc=32'h0, if_ready=1.
REQ-034 Streaming: id_ready=1, words 32'h0000_2300 @0x0, 32'h0000_1514 @0x4 on consecutive cycles -> each appears one cycle later, no bubble.
REQ-035 Backpressure: id_ready=0 for 3 cycles with 32'h0700_6430 @0x8 held -> id_* stable; skid build accepts exactly one more word, then if_ready=0; release -> both words emerge in order.
REQ-036 Flush: flush with if_valid=1 and two words held -> next cycle id_valid=0, id_instr=NOP_INSTR, incoming word never appears.
REQ-037 Misalign: accept word @0x6 -> id_misalign=1 with id_pc=0x6; the following word @0x8 -> id_misalign=0.
REQ-038 Reset mid-stall: rst while skid full and id_ready=0 -> next cycle empty, if_ready=1, held words never presented.
